sram_port_arbiter: RTL

Shares one SRAM-like memory port between the instruction-fetch request channel and the load/store data channel. Each cycle it picks one requester, forwards its request, and records the source of every accepted request in an in-order tracking FIFO. Read data and data_ok are returned to the correct requester. It sits between the IF/MEM stages and the single external memory/bridge port.

---
 rtl/sram_port_arbiter_pkg.sv | 18 +
 rtl/sram_port_arbiter_if.sv | 19 +
 rtl/sram_port_arbiter_arb_order_fifo.sv | 56 +++++
 rtl/sram_port_arbiter_chk.sv | 16 +
 rtl/sram_port_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: source ids, default sizing
// and the forwarded command bundle.
package sram_port_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// SRAM-like request/response channel; master issues requests, slave accepts
// them and returns data in order.
interface sram_port_arbiter_if;

    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);

endinterface

// File: rtl/sram_port_arbiter_arb_order_fifo.sv
// In-order source-id tracker: 1-bit wide synchronous FIFO of DEPTH entries
// (power of two); pointers wrap naturally at log2(DEPTH) bits.
module arb_order_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] slots_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign head      = slots_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_r  <= {DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                slots_r[wr_ptr_r] <= din;
                wr_ptr_r          <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter_chk.sv
// Protocol checker for the arbiter, compiled only when ARB_ASSERT_EN is
// defined: flags a response arriving with nothing outstanding.
`ifdef ARB_ASSERT_EN
module sram_port_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic mem_data_ok,
    input logic fifo_empty
);

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(mem_data_ok && fifo_empty))
        else $error("response with no outstanding request");

endmodule
`endif

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store with
// zero-latency grant and in-order response routing. ARB_STARVE_GUARD_EN
// enables the inst anti-starvation counter; ARB_ASSERT_EN adds the checker.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   inst_bus,
    sram_port_arbiter_if.slave   data_bus,
    sram_port_arbiter_if.master  mem_bus
);

    logic     lock_valid_r;
    logic     lock_src_r;
    logic     prefer_inst_s;
    logic     grant_src_s;
    logic     grant_req_s;
    logic     mem_req_s;
    logic     accept_s;
    logic     resp_s;
    logic     fifo_full_s;
    logic     fifo_empty_s;
    logic     fifo_head_s;
    mem_cmd_t cmd_s;
    logic     unused_inst_fields_s;

    // Instruction fetches never write; their write fields are dropped.
    assign unused_inst_fields_s = ^{inst_bus.wr, inst_bus.wstrb, inst_bus.wdata};

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt_r;

    assign prefer_inst_s = (starve_cnt_r == SW'(STARVE_LIMIT));

    // Count data wins over a waiting fetch; saturates until inst is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (accept_s && (grant_src_s == SRC_INST)) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (accept_s && inst_bus.req && !prefer_inst_s) begin
            starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    logic unused_starve_s;
    assign unused_starve_s = (STARVE_LIMIT != 0);
    assign prefer_inst_s   = 1'b0;
`endif

    // Grant: a presented-but-refused request keeps the port so its fields hold.
    always_comb begin
        grant_src_s = SRC_INST;
        if (lock_valid_r) begin
            grant_src_s = lock_src_r;
        end else if (prefer_inst_s && inst_bus.req) begin
            grant_src_s = SRC_INST;
        end else if (data_bus.req) begin
            grant_src_s = SRC_DATA;
        end else begin
            grant_src_s = SRC_INST;
        end
    end

    assign grant_req_s = (grant_src_s == SRC_DATA) ? data_bus.req : inst_bus.req;
    assign mem_req_s   = grant_req_s && !fifo_full_s && !rst;
    assign accept_s    = mem_req_s && mem_bus.addr_ok;
    assign resp_s      = mem_bus.data_ok && !fifo_empty_s && !rst;

    // Forwarded command; idle port drives zeros.
    always_comb begin
        cmd_s = '0;
        if (!mem_req_s) begin
            cmd_s = '0;
        end else if (grant_src_s == SRC_DATA) begin
            cmd_s = '{wr: data_bus.wr, wstrb: data_bus.wstrb,
                      addr: data_bus.addr, wdata: data_bus.wdata};
        end else begin
            cmd_s = '{wr: 1'b0, wstrb: 4'h0, addr: inst_bus.addr, wdata: 32'h0};
        end
    end

    assign mem_bus.req   = mem_req_s;
    assign mem_bus.wr    = cmd_s.wr;
    assign mem_bus.wstrb = cmd_s.wstrb;
    assign mem_bus.addr  = cmd_s.addr;
    assign mem_bus.wdata = cmd_s.wdata;

    assign inst_bus.addr_ok = accept_s && (grant_src_s == SRC_INST);
    assign data_bus.addr_ok = accept_s && (grant_src_s == SRC_DATA);
    assign inst_bus.data_ok = resp_s && (fifo_head_s == SRC_INST);
    assign data_bus.data_ok = resp_s && (fifo_head_s == SRC_DATA);
    assign inst_bus.rdata   = inst_bus.data_ok ? mem_bus.rdata : 32'h0;
    assign data_bus.rdata   = data_bus.data_ok ? mem_bus.rdata : 32'h0;

    // Lock tracking for requests the port has not yet accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid_r <= 1'b0;
            lock_src_r   <= SRC_INST;
        end else if (accept_s) begin
            lock_valid_r <= 1'b0;
            lock_src_r   <= lock_src_r;
        end else if (mem_req_s) begin
            lock_valid_r <= 1'b1;
            lock_src_r   <= grant_src_s;
        end else begin
            lock_valid_r <= lock_valid_r;
            lock_src_r   <= lock_src_r;
        end
    end

    arb_order_fifo #(.DEPTH(DEPTH)) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .pop   (resp_s),
        .din   (grant_src_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

`ifdef ARB_ASSERT_EN
    sram_port_arbiter_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .mem_data_ok (mem_bus.data_ok),
        .fifo_empty  (fifo_empty_s)
    );
`endif

endmodule
